// File: rtl/ieee_1149_10_pkt_rx_checker_if.sv
// Symbol-in / packet-and-status-out bundle of the 1149.10 PEDDA receive checker.
// master: the symbol source that also watches the results; slave: the checker.
interface ieee_1149_10_pkt_rx_checker_if #(
  parameter int PAYLOAD_BYTES = 8
);
  logic [7:0]                 ieee_1149_10_parallel_in;
  logic                       tb_k_in;
  logic                       pkt_valid;
  logic [7:0]                 pkt_opcode;
  logic [8*PAYLOAD_BYTES-1:0] pkt_payload;
  logic                       status_valid;
  logic [2:0]                 pedda_mst_status1_out;

  modport master (
    output ieee_1149_10_parallel_in, tb_k_in,
    input  pkt_valid, pkt_opcode, pkt_payload, status_valid, pedda_mst_status1_out
  );

  modport slave (
    input  ieee_1149_10_parallel_in, tb_k_in,
    output pkt_valid, pkt_opcode, pkt_payload, status_valid, pedda_mst_status1_out
  );
endinterface

// File: rtl/ieee_1149_10_pkt_rx_checker.sv
// ieee_1149_10_pkt_rx_checker
// Receive-side parser/checker for the 1149.10 PEDDA symbol stream. Frames
// SOP / opcode / payload / [CRC] / EOP, reports accepted packets, and drives a
// registered 3-bit status code: 0 ok, 1 opcode, 2 K-char in body, 3 EOP,
// 4 CRC, 6 response timeout, 7 idle overflow.
// Optional CRC-16-CCITT check over opcode+payload: define IEEE_1149_10_CRC_CHECK_EN.
module ieee_1149_10_pkt_rx_checker #(
  parameter int PAYLOAD_BYTES = 8,
  parameter int IDLE_MAX      = 16,
  parameter int RSP_TIMEOUT   = 1000
) (
  input  logic                          ieee_1149_10_clk,
  input  logic                          reset,
  ieee_1149_10_pkt_rx_checker_if.slave  bus
);
  localparam int PW     = 8 * PAYLOAD_BYTES;
  localparam int CNT_W  = $clog2(PAYLOAD_BYTES + 1);
  localparam int IDLE_W = $clog2(IDLE_MAX + 1);
  localparam int TO_W   = $clog2(RSP_TIMEOUT + 1);

  localparam logic [7:0] K_SOP  = 8'hFB;
  localparam logic [7:0] K_EOP  = 8'hFD;
  localparam logic [7:0] K_IDLE = 8'hBC;

  localparam logic [2:0] CODE_OK    = 3'd0;
  localparam logic [2:0] CODE_OPC   = 3'd1;
  localparam logic [2:0] CODE_KCHAR = 3'd2;
  localparam logic [2:0] CODE_EOP   = 3'd3;
`ifdef IEEE_1149_10_CRC_CHECK_EN
  localparam logic [2:0] CODE_CRC   = 3'd4;
`endif
  localparam logic [2:0] CODE_TMO   = 3'd6;
  localparam logic [2:0] CODE_IDLE  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_OPCODE  = 3'd1,
    S_PAYLOAD = 3'd2,
`ifdef IEEE_1149_10_CRC_CHECK_EN
    S_CRC     = 3'd3,
`endif
    S_EOP     = 3'd4,
    S_DRAIN   = 3'd5
  } state_e;

`ifdef IEEE_1149_10_CRC_CHECK_EN
  // One byte of CRC-16-CCITT (poly 0x1021), MSB first.
  function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) begin
        c = {c[14:0], 1'b0} ^ 16'h1021;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction
`endif

  state_e            r_state;
  state_e            w_state_nxt;
  logic [7:0]        w_sym;
  logic              w_k;
  logic              w_is_sop;
  logic              w_is_eop;
  logic              w_is_idle;
  logic              w_op_ok;
  logic              w_last_byte;
  logic              w_fsm_err;
  logic [2:0]        w_fsm_code;
  logic              w_accept;
  logic [CNT_W-1:0]  r_cnt;
  logic [PW-1:0]     r_shift;
  logic [7:0]        r_op;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic              w_idle_hit;
  logic              r_to_armed;
  logic [TO_W-1:0]   r_to_cnt;
  logic              w_to_hit;
  logic              w_evt;
  logic [2:0]        w_evt_code;
  logic              r_pkt_valid;
  logic [7:0]        r_pkt_opcode;
  logic [PW-1:0]     r_pkt_payload;
  logic              r_status_valid;
  logic [2:0]        r_status;
`ifdef IEEE_1149_10_CRC_CHECK_EN
  logic [15:0]       r_crc;
  logic [7:0]        r_crc_hi;
  logic              r_crc_idx;
  logic              w_crc_ok;
`endif

  assign w_sym       = bus.ieee_1149_10_parallel_in;
  assign w_k         = bus.tb_k_in;
  assign w_is_sop    = w_k && (w_sym == K_SOP);
  assign w_is_eop    = w_k && (w_sym == K_EOP);
  assign w_is_idle   = w_k && (w_sym == K_IDLE);
  assign w_op_ok     = !w_k && (w_sym >= 8'h81) && (w_sym <= 8'h84);
  assign w_last_byte = (r_cnt == CNT_W'(PAYLOAD_BYTES - 1));
`ifdef IEEE_1149_10_CRC_CHECK_EN
  assign w_crc_ok    = ({r_crc_hi, w_sym} == r_crc);
`endif

  // FSM state register.
  always_ff @(posedge ieee_1149_10_clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state decode from the current symbol.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_is_sop) w_state_nxt = S_OPCODE;
        else          w_state_nxt = S_IDLE;
      end
      S_OPCODE: begin
        if (w_op_ok) w_state_nxt = S_PAYLOAD;
        else         w_state_nxt = S_DRAIN;
      end
      S_PAYLOAD: begin
        if (w_k) begin
          w_state_nxt = S_DRAIN;
        end else if (w_last_byte) begin
`ifdef IEEE_1149_10_CRC_CHECK_EN
          w_state_nxt = S_CRC;
`else
          w_state_nxt = S_EOP;
`endif
        end else begin
          w_state_nxt = S_PAYLOAD;
        end
      end
`ifdef IEEE_1149_10_CRC_CHECK_EN
      S_CRC: begin
        if (w_k)            w_state_nxt = S_DRAIN;
        else if (!r_crc_idx) w_state_nxt = S_CRC;
        else if (w_crc_ok)  w_state_nxt = S_EOP;
        else                w_state_nxt = S_DRAIN;
      end
`endif
      S_EOP: begin
        if (w_is_eop) w_state_nxt = S_IDLE;
        else          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_is_eop || w_is_idle) w_state_nxt = S_IDLE;
        else if (w_is_sop)         w_state_nxt = S_OPCODE;
        else                       w_state_nxt = S_DRAIN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: framing error code or packet acceptance for this symbol.
  always_comb begin
    w_fsm_err  = 1'b0;
    w_fsm_code = CODE_OK;
    w_accept   = 1'b0;
    case (r_state)
      S_OPCODE: begin
        if (w_k) begin
          w_fsm_err  = 1'b1;
          w_fsm_code = CODE_KCHAR;
        end else if (!w_op_ok) begin
          w_fsm_err  = 1'b1;
          w_fsm_code = CODE_OPC;
        end else begin
          w_fsm_err  = 1'b0;
        end
      end
      S_PAYLOAD: begin
        if (w_k) begin
          w_fsm_err  = 1'b1;
          w_fsm_code = w_is_eop ? CODE_EOP : CODE_KCHAR;
        end else begin
          w_fsm_err  = 1'b0;
        end
      end
`ifdef IEEE_1149_10_CRC_CHECK_EN
      S_CRC: begin
        if (w_k) begin
          w_fsm_err  = 1'b1;
          w_fsm_code = w_is_eop ? CODE_EOP : CODE_KCHAR;
        end else if (r_crc_idx && !w_crc_ok) begin
          w_fsm_err  = 1'b1;
          w_fsm_code = CODE_CRC;
        end else begin
          w_fsm_err  = 1'b0;
        end
      end
`endif
      S_EOP: begin
        if (w_is_eop) begin
          w_accept   = 1'b1;
        end else begin
          w_fsm_err  = 1'b1;
          w_fsm_code = w_k ? CODE_KCHAR : CODE_EOP;
        end
      end
      default: begin
        w_fsm_err  = 1'b0;
      end
    endcase
  end

  // Packet datapath: opcode capture, payload shift-in (first byte ends in MSBs), running CRC.
  always_ff @(posedge ieee_1149_10_clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_shift   <= '0;
      r_op      <= 8'h00;
`ifdef IEEE_1149_10_CRC_CHECK_EN
      r_crc     <= 16'hFFFF;
      r_crc_hi  <= 8'h00;
      r_crc_idx <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_OPCODE: begin
          if (!w_k) begin
            r_op      <= w_sym;
            r_cnt     <= '0;
`ifdef IEEE_1149_10_CRC_CHECK_EN
            r_crc     <= crc16_ccitt_byte(16'hFFFF, w_sym);
            r_crc_idx <= 1'b0;
`endif
          end
        end
        S_PAYLOAD: begin
          if (!w_k) begin
            r_shift <= {r_shift[PW-9:0], w_sym};
            r_cnt   <= r_cnt + CNT_W'(1);
`ifdef IEEE_1149_10_CRC_CHECK_EN
            r_crc   <= crc16_ccitt_byte(r_crc, w_sym);
`endif
          end
        end
`ifdef IEEE_1149_10_CRC_CHECK_EN
        S_CRC: begin
          if (!w_k) begin
            r_crc_hi  <= w_sym;
            r_crc_idx <= ~r_crc_idx;
          end
        end
`endif
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // A consecutive-IDLE run reports once when it reaches IDLE_MAX.
  assign w_idle_hit = w_is_idle && (r_idle_cnt == IDLE_W'(IDLE_MAX - 1));
  // Consecutive-IDLE counter, saturating at IDLE_MAX, cleared by any other symbol.
  always_ff @(posedge ieee_1149_10_clk or negedge reset) begin
    if (!reset) begin
      r_idle_cnt <= '0;
    end else if (!w_is_idle) begin
      r_idle_cnt <= '0;
    end else if (r_idle_cnt != IDLE_W'(IDLE_MAX)) begin
      r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
    end else begin
      r_idle_cnt <= r_idle_cnt;
    end
  end

  // The response window ends on the RSP_TIMEOUT-th cycle counted from pkt_valid.
  assign w_to_hit = r_to_armed && !w_is_sop && (r_to_cnt == TO_W'(RSP_TIMEOUT - 1));
  // Response timer: armed with pkt_valid, disarmed by a new SOP or by firing once.
  always_ff @(posedge ieee_1149_10_clk or negedge reset) begin
    if (!reset) begin
      r_to_armed <= 1'b0;
      r_to_cnt   <= '0;
    end else if (w_accept) begin
      r_to_armed <= 1'b1;
      r_to_cnt   <= '0;
    end else if (r_to_armed && (w_is_sop || w_to_hit)) begin
      r_to_armed <= 1'b0;
      r_to_cnt   <= '0;
    end else if (r_to_armed) begin
      r_to_cnt   <= r_to_cnt + TO_W'(1);
    end else begin
      r_to_cnt   <= r_to_cnt;
    end
  end

  // Status arbitration: framing error > ok > timeout > idle overflow; losers are dropped.
  always_comb begin
    w_evt      = 1'b1;
    w_evt_code = CODE_OK;
    if (w_fsm_err) begin
      w_evt_code = w_fsm_code;
    end else if (w_accept) begin
      w_evt_code = CODE_OK;
    end else if (w_to_hit) begin
      w_evt_code = CODE_TMO;
    end else if (w_idle_hit) begin
      w_evt_code = CODE_IDLE;
    end else begin
      w_evt      = 1'b0;
    end
  end

  // Registered outputs; status and packet fields hold until their next update.
  always_ff @(posedge ieee_1149_10_clk or negedge reset) begin
    if (!reset) begin
      r_pkt_valid    <= 1'b0;
      r_pkt_opcode   <= 8'h00;
      r_pkt_payload  <= '0;
      r_status_valid <= 1'b0;
      r_status       <= 3'd0;
    end else begin
      r_pkt_valid    <= w_accept;
      r_status_valid <= w_evt;
      if (w_evt) begin
        r_status <= w_evt_code;
      end
      if (w_accept) begin
        r_pkt_opcode  <= r_op;
        r_pkt_payload <= r_shift;
      end
    end
  end

  assign bus.pkt_valid             = r_pkt_valid;
  assign bus.pkt_opcode            = r_pkt_opcode;
  assign bus.pkt_payload           = r_pkt_payload;
  assign bus.status_valid          = r_status_valid;
  assign bus.pedda_mst_status1_out = r_status;
endmodule
